// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// State codes and register constants used across the control slice.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_FAULT    = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating event counter used for pipeline performance statistics.
// Holds at all-ones once full.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline registers and PC.
// Handles load-use, redirects and slow data memory with a watchdog.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_write_reg,
  input  logic             exmem_jump_or_branch,
  input  logic             exmem_mem_access,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  hz_state_e      state;
  hz_state_e      stateNext;
  logic [WCW-1:0] waitCnt;
  logic [WCW-1:0] waitCntNext;
  logic           faultQ;
  logic           faultNext;
  logic           loadUse;
  logic           memBusy;
  logic           goRun;
  logic           redirect;

  always_comb begin
    loadUse = idex_mem_read
            && (idex_write_reg != REG_ZERO)
            && ((idex_write_reg == id_rs)
             || (id_uses_rt && (idex_write_reg == id_rt)));
    memBusy = exmem_mem_access && !mem_ready;
  end

  // Cycles that behave as an ordinary RUN cycle after memory is settled
  always_comb begin
    unique case (state)
      HZ_RUN:      goRun = !memBusy;
      HZ_MEM_WAIT: goRun = mem_ready;
      default:     goRun = 1'b0;
    endcase
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    faultNext   = faultQ;
    unique case (state)
      HZ_RUN: begin
        if (memBusy) begin
          stateNext   = HZ_MEM_WAIT;
          waitCntNext = WCW'(1);
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_ready) begin
          stateNext   = HZ_RUN;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCnt + 1'b1;
          if (waitCnt >= WCW'(MEM_TIMEOUT - 1)) begin
            stateNext = HZ_FAULT;
            faultNext = 1'b1;
          end
        end
      end
      default: begin
        stateNext = HZ_FAULT;
        faultNext = 1'b1;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    idex_write   = 1'b0;
    exmem_write  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b1;
    redirect     = 1'b0;
    if (goRun) begin
      priority case (1'b1)
        exmem_jump_or_branch: begin
          pc_write     = 1'b1;
          ifid_write   = 1'b1;
          idex_write   = 1'b1;
          exmem_write  = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_flush  = 1'b1;
          memwb_bubble = 1'b0;
          redirect     = 1'b1;
        end
        loadUse: begin
          idex_write   = 1'b1;
          exmem_write  = 1'b1;
          idex_flush   = 1'b1;
          memwb_bubble = 1'b0;
        end
        default: begin
          pc_write     = 1'b1;
          ifid_write   = 1'b1;
          idex_write   = 1'b1;
          exmem_write  = 1'b1;
          memwb_bubble = 1'b0;
        end
      endcase
    end
    // Hold the pipeline frozen and cleared while in reset
    if (!reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
      redirect     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= HZ_RUN;
      waitCnt <= '0;
      faultQ  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      faultQ  <= faultNext;
    end
  end

  assign mem_fault = faultQ;

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for the pipeline hazard controller.
// Small counters so saturation is reachable quickly.
module tb_pipeline_hazard_controller;

  localparam int TO = 16;
  localparam int CW = 4;

  localparam logic [7:0] O_RST  = 8'h0F;
  localparam logic [7:0] O_NORM = 8'hF0;
  localparam logic [7:0] O_LU   = 8'h34;
  localparam logic [7:0] O_RED  = 8'hFE;
  localparam logic [7:0] O_HOLD = 8'h01;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, idex_write_reg;
  logic          id_uses_rt, idex_mem_read;
  logic          exmem_jump_or_branch, exmem_mem_access, mem_ready;
  logic          pc_write, ifid_write, idex_write, exmem_write;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_bubble;
  logic          mem_fault;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [7:0]    outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .id_rs                (id_rs),
    .id_rt                (id_rt),
    .id_uses_rt           (id_uses_rt),
    .idex_mem_read        (idex_mem_read),
    .idex_write_reg       (idex_write_reg),
    .exmem_jump_or_branch (exmem_jump_or_branch),
    .exmem_mem_access     (exmem_mem_access),
    .mem_ready            (mem_ready),
    .pc_write             (pc_write),
    .ifid_write           (ifid_write),
    .idex_write           (idex_write),
    .exmem_write          (exmem_write),
    .ifid_flush           (ifid_flush),
    .idex_flush           (idex_flush),
    .exmem_flush          (exmem_flush),
    .memwb_bubble         (memwb_bubble),
    .mem_fault            (mem_fault),
    .stall_cycles         (stall_cycles),
    .flush_events         (flush_events)
  );

  assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                 ifid_flush, idex_flush, exmem_flush, memwb_bubble};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    idex_mem_read = 1'b0; idex_write_reg = 5'd0;
    exmem_jump_or_branch = 1'b0;
    exmem_mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_outs", {24'd0, outs}, {24'd0, O_RST});
    check("rst_fault", {31'd0, mem_fault}, 32'd0);
    check("rst_stall", {28'd0, stall_cycles}, 32'd0);
    cyc();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    idex_mem_read = 1'b1; idex_write_reg = 5'd8; id_rs = 5'd8;
    #2;
    check("rst_hz_outs", {24'd0, outs}, {24'd0, O_RST});
    cyc(); cyc();
    idle();
    check("rst_flush", {28'd0, flush_events}, 32'd0);
    reset = 1'b1;
    #1;
    check("norm_outs", {24'd0, outs}, {24'd0, O_NORM});
    cyc(); cyc(); cyc();
    check("norm_stall", {28'd0, stall_cycles}, 32'd0);
    check("norm_flush", {28'd0, flush_events}, 32'd0);

    idex_mem_read = 1'b1; idex_write_reg = 5'd8; id_rs = 5'd8;
    #1;
    check("lu_rs_outs", {24'd0, outs}, {24'd0, O_LU});
    cyc();
    idle();
    #1;
    check("lu_after", {24'd0, outs}, {24'd0, O_NORM});
    check("lu_stall", {28'd0, stall_cycles}, 32'd1);

    idex_mem_read = 1'b1; idex_write_reg = 5'd9;
    id_rt = 5'd9; id_uses_rt = 1'b1;
    #1;
    check("lu_rt_outs", {24'd0, outs}, {24'd0, O_LU});
    id_uses_rt = 1'b0;
    #1;
    check("lu_rt_unused", {24'd0, outs}, {24'd0, O_NORM});
    idex_write_reg = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    check("lu_r0_outs", {24'd0, outs}, {24'd0, O_NORM});
    cyc();
    check("lu_r0_stall", {28'd0, stall_cycles}, 32'd1);

    idle();
    idex_mem_read = 1'b1; idex_write_reg = 5'd8; id_rs = 5'd8;
    exmem_jump_or_branch = 1'b1;
    #1;
    check("red_outs", {24'd0, outs}, {24'd0, O_RED});
    cyc();
    idle();
    check("red_flush", {28'd0, flush_events}, 32'd1);
    check("red_stall", {28'd0, stall_cycles}, 32'd1);

    exmem_mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_outs%0d", i), {24'd0, outs}, {24'd0, O_HOLD});
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    check("mw_ready", {24'd0, outs}, {24'd0, O_NORM});
    cyc();
    check("mw_stall", {28'd0, stall_cycles}, 32'd4);
    exmem_mem_access = 1'b0; mem_ready = 1'b0;
    #1;
    check("mw_back_run", {24'd0, outs}, {24'd0, O_NORM});

    exmem_mem_access = 1'b1;
    cyc();
    exmem_jump_or_branch = 1'b1; mem_ready = 1'b1;
    #1;
    check("mw_red_outs", {24'd0, outs}, {24'd0, O_RED});
    cyc();
    idle();
    check("mw_red_flush", {28'd0, flush_events}, 32'd2);

    do_reset();
    exmem_mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      check($sformatf("to_outs%0d", i), {24'd0, outs}, {24'd0, O_HOLD});
      check($sformatf("to_nofault%0d", i), {31'd0, mem_fault}, 32'd0);
      cyc();
    end
    check("to_fault", {31'd0, mem_fault}, 32'd1);
    exmem_mem_access = 1'b0; mem_ready = 1'b1;
    #1;
    check("flt_outs", {24'd0, outs}, {24'd0, O_HOLD});
    cyc(); cyc();
    check("flt_outs2", {24'd0, outs}, {24'd0, O_HOLD});
    check("flt_sticky", {31'd0, mem_fault}, 32'd1);
    check("flt_stall_sat", {28'd0, stall_cycles}, 32'hF);
    idle();
    do_reset();
    check("flt_cleared", {24'd0, outs}, {24'd0, O_NORM});

    idex_mem_read = 1'b1; idex_write_reg = 5'd3; id_rs = 5'd3;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 14) check("sat_14", {28'd0, stall_cycles}, 32'd14);
      if (i == 15) check("sat_15", {28'd0, stall_cycles}, 32'hF);
    end
    check("sat_hold", {28'd0, stall_cycles}, 32'hF);
    idle();
    cyc();
    check("sat_flush0", {28'd0, flush_events}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
